// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute stage and the sequential divider.
// The master drives operands and start; the slave returns busy/done/result.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             isDiv;
    logic             isMod;
    logic             isSigned;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start, A, B, isDiv, isMod, isSigned,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, A, B, isDiv, isMod, isSigned,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per clock, signed or unsigned.
// Operands are reduced to magnitudes on acceptance, divided over WIDTH cycles,
// and the signs are restored in a single FIX cycle that also registers result.
module seq_divider #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CW-1:0]    r_cnt;       // remaining quotient bits
    logic [WIDTH-1:0] r_dvs;       // divisor magnitude
    logic [WIDTH-1:0] r_dvd;       // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0] r_rem;       // partial remainder magnitude
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_is_div;
    logic             r_is_mod;
    logic             r_dz;        // current operation has a zero divisor
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_div_by_zero;

    logic             w_accept;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic             w_cnt_last;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_remf;
    logic [WIDTH-1:0] w_sel;

    // A start coinciding with the done pulse is dropped; the next cycle accepts.
    assign w_accept   = (r_state == IDLE) && bus.start && !r_done;
    // With SIGNED_EN=0 this folds to 0 and the sign-fix logic disappears.
    assign w_signed   = SIGNED_EN && bus.isSigned;
    assign w_a_neg    = w_signed && bus.A[WIDTH-1];
    assign w_b_neg    = w_signed && bus.B[WIDTH-1];
    // Negating the most-negative value yields itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    assign w_a_mag    = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag    = w_b_neg ? -bus.B : bus.B;
    assign w_b_zero   = (bus.B == '0);
    assign w_cnt_last = (r_cnt == CW'(1));

    // The partial remainder is always below the divisor, so WIDTH+1 bits hold
    // both the shifted remainder and the signed trial difference.
    assign w_shift_rem = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_dvs};
    assign w_fits      = ~w_trial[WIDTH];

    assign w_quot = r_q_neg ? -r_dvd : r_dvd;
    assign w_remf = r_r_neg ? -r_rem : r_rem;
    assign w_sel  = r_dz     ? '0     :
                    r_is_div ? w_quot :
                    r_is_mod ? w_remf : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path leaves w_state_next unassigned (latch).
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_b_zero ? FIX : CALC;
            CALC: if (w_cnt_last) w_state_next = FIX;
            FIX:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, shift/subtract iterations and result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_dvs         <= '0;
            r_dvd         <= '0;
            r_rem         <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_is_div      <= 1'b0;
            r_is_mod      <= 1'b0;
            r_dz          <= 1'b0;
            r_result      <= '0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_div      <= bus.isDiv;
                        r_is_mod      <= bus.isMod;
                        r_dz          <= w_b_zero;
                        r_div_by_zero <= 1'b0;
                        r_dvs         <= w_b_mag;
                        r_dvd         <= w_a_mag;
                        r_rem         <= '0;
                        r_q_neg       <= w_a_neg ^ w_b_neg;
                        r_r_neg       <= w_a_neg;
                        r_cnt         <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt - CW'(1);
                end
                FIX: begin
                    r_result      <= w_sel;
                    r_div_by_zero <= r_dz;
                    r_done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a 32-bit signed-capable instance and an
// 8-bit unsigned-only instance, driven from a vector table, random operands
// checked against an arithmetic reference, and hand-written timing sequences.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst_n;
    int   n_err = 0;
    int   n_checks = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(32)) bus32();
    seq_divider_if #(.WIDTH(8))  bus8();

    seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    seq_divider #(.WIDTH(8),  .SIGNED_EN(1'b0)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        d;
        logic        m;
        logic        s;
        logic [31:0] exp_res;
        logic        exp_dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division on 64-bit values; SV '/' truncates toward
    // zero and '%' follows the dividend sign, matching the required semantics.
    function automatic logic [32:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                          input logic d, input logic m, input logic s);
        longint na, nb, q, r;
        logic [31:0] sel;
        if (b == 32'h0) return {1'b1, 32'h0};
        na  = s ? longint'($signed(a)) : longint'(a);
        nb  = s ? longint'($signed(b)) : longint'(b);
        q   = na / nb;
        r   = na % nb;
        sel = d ? q[31:0] : (m ? r[31:0] : 32'h0);
        return {1'b0, sel};
    endfunction

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic d,
                        input logic m, input logic s, input string tag,
                        output logic [31:0] res, output logic dz, output int lat, output int bcnt);
        @(negedge clk);
        bus32.A = a; bus32.B = b; bus32.isDiv = d; bus32.isMod = m; bus32.isSigned = s;
        bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        check({tag, " dz_clear_on_start"}, bus32.div_by_zero, 0);
        lat = 0; bcnt = 0;
        while (!bus32.done && lat < 100) begin
            if (bus32.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " done_seen"}, bus32.done, 1);
        res = bus32.result;
        dz  = bus32.div_by_zero;
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, bus32.done, 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic d,
                       input logic m, input logic s,
                       output logic [7:0] res, output logic dz, output int lat);
        @(negedge clk);
        bus8.A = a; bus8.B = b; bus8.isDiv = d; bus8.isMod = m; bus8.isSigned = s;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus8.result;
        dz  = bus8.div_by_zero;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] res;
        logic [7:0]  res8;
        logic        dz;
        int          lat, bcnt, exp_lat, dones;
        logic [32:0] exp;

        vecs.push_back('{32'd100,        32'd7,          1, 0, 0, 32'd14,         0});
        vecs.push_back('{32'd100,        32'd7,          0, 1, 0, 32'd2,          0});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1, 0, 1, 32'hFFFF_FFFD,  0});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          0, 1, 1, 32'hFFFF_FFFF,  0});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1, 0, 0, 32'h7FFF_FFFC,  0});
        vecs.push_back('{32'h0000_1234,  32'd0,          1, 0, 0, 32'h0,          1});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1, 0, 1, 32'h8000_0000,  0});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  0, 1, 1, 32'h0,          0});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  0, 0, 1, 32'h0,          0});
        vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1, 0, 1, 32'hFFFF_FFFD,  0});
        vecs.push_back('{32'd7,          32'hFFFF_FFFE,  0, 1, 1, 32'd1,          0});
        vecs.push_back('{32'h0000_1234,  32'd0,          0, 1, 1, 32'h0,          1});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1, 0, 0, 32'hFFFF_FFFF,  0});
        vecs.push_back('{32'd5,          32'd10,         0, 1, 0, 32'd5,          0});
        vecs.push_back('{32'd100,        32'd7,          1, 1, 0, 32'd14,         0});

        rst_n = 1'b0;
        bus32.start = 0; bus32.A = '0; bus32.B = '0; bus32.isDiv = 0; bus32.isMod = 0; bus32.isSigned = 0;
        bus8.start  = 0; bus8.A  = '0; bus8.B  = '0; bus8.isDiv  = 0; bus8.isMod  = 0; bus8.isSigned  = 0;
        #12;
        check("reset busy",   bus32.busy, 0);
        check("reset done",   bus32.done, 0);
        check("reset result", bus32.result, 0);
        check("reset dz",     bus32.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        foreach (vecs[i]) begin
            op32(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].m, vecs[i].s,
                 $sformatf("vec%0d", i), res, dz, lat, bcnt);
            exp_lat = (vecs[i].b == 32'h0) ? 1 : 33;
            check($sformatf("vec%0d result", i),  res, vecs[i].exp_res);
            check($sformatf("vec%0d dz", i),      dz,  vecs[i].exp_dz);
            check($sformatf("vec%0d latency", i), lat, exp_lat);
            check($sformatf("vec%0d busy_cycles", i), bcnt, exp_lat);
        end

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic        d, m, s;
            int          sel;
            a   = $urandom;
            sel = $urandom_range(0, 7);
            b   = (sel == 0) ? 32'h0 :
                  (sel < 3)  ? 32'($urandom_range(1, 15)) :
                  (sel == 3) ? 32'hFFFF_FFFF : 32'($urandom);
            if (sel == 4) a = 32'h8000_0000;
            d = 1'($urandom); m = 1'($urandom); s = 1'($urandom);
            exp = ref32(a, b, d, m, s);
            op32(a, b, d, m, s, $sformatf("rnd%0d", i), res, dz, lat, bcnt);
            check($sformatf("rnd%0d result a=%0h b=%0h d%0d m%0d s%0d", i, a, b, d, m, s),
                  res, exp[31:0]);
            check($sformatf("rnd%0d dz", i), dz, exp[32]);
        end

        // A second start while busy is ignored.
        @(negedge clk);
        bus32.A = 32'd50; bus32.B = 32'd5; bus32.isDiv = 1; bus32.isMod = 0; bus32.isSigned = 0;
        bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        lat = 0;
        while (!bus32.done && lat < 100) begin
            if (lat == 9) begin
                bus32.A = 32'd999; bus32.B = 32'd3; bus32.start = 1'b1;
            end else begin
                bus32.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus32.start = 1'b0;
        check("stray_start result", bus32.result, 32'd10);
        check("stray_start latency", lat, 33);

        // A start during the done cycle is ignored.
        bus32.A = 32'd77; bus32.B = 32'd7; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        check("start_on_done busy", bus32.busy, 0);
        check("start_on_done done", bus32.done, 0);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        bus32.A = 32'd200; bus32.B = 32'd3; bus32.isDiv = 1; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset busy",   bus32.busy, 0);
        check("midreset done",   bus32.done, 0);
        check("midreset result", bus32.result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (bus32.done) dones++;
        end
        check("midreset no_done", dones, 0);

        // Unsigned-only 8-bit instance: isSigned has no effect.
        op8(8'hF0, 8'h03, 1, 0, 1, res8, dz, lat);
        check("w8 quotient", res8, 8'h50);
        check("w8 latency", lat, 9);
        op8(8'hF0, 8'h03, 0, 1, 1, res8, dz, lat);
        check("w8 remainder", res8, 8'h00);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a, b;
            logic       d;
            a = 8'($urandom);
            b = 8'($urandom_range(1, 255));
            d = 1'($urandom);
            op8(a, b, d, !d, 1, res8, dz, lat);
            check($sformatf("w8 rnd%0d a=%0h b=%0h d%0d", i, a, b, d),
                  res8, d ? 8'(a / b) : 8'(a % b));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
